// File: rtl/memory_access_pkg.sv
// Shared types for the memory-access pipeline stage: FSM states and the
// control bundle carried from execute through M into writeback.
package memory_pkg;

    typedef enum logic {IDLE, ACCESS} state_t;

    typedef struct packed {
        logic       branch;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       mem_to_reg;
        logic [4:0] rd;
    } ctrl_t;

    function automatic logic is_mem(input ctrl_t c);
        return c.mem_read | c.mem_write;
    endfunction

endpackage

// File: rtl/memory_access_exmem_reg.sv
// Enable-qualified pipeline register with synchronous active-low reset;
// used for both the M and W stage registers.
module exmem_reg #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (!reset)  q <= '0;
        else if (en) q <= d;
    end

endmodule

// File: rtl/memory_access.sv
// Memory-access pipeline stage: M register, data-memory handshake FSM and W register.
// Optional feature macro: MEM_MISALIGN_CHECK_EN (misaligned memory ops retire without access).
module memory_access
    import memory_pkg::*;
#(
    parameter int N = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         valid_E,
    input  logic [N-1:0] aluResult_E,
    input  logic [N-1:0] writeData_E,
    input  logic [N-1:0] PCBranch_E,
    input  logic         zero_E,
    input  logic         Branch_E,
    input  logic         MemRead_E,
    input  logic         MemWrite_E,
    input  logic         regWrite_E,
    input  logic         memtoReg_E,
    input  logic [4:0]   rd_E,
    output logic         ready_E,
    output logic         PCSrc_M,
    output logic [N-1:0] PCBranch_M,
    output logic         dm_req,
    output logic         dm_we,
    output logic [N-1:0] dm_addr,
    output logic [N-1:0] dm_wdata,
    input  logic         dm_ack,
    input  logic [N-1:0] dm_rdata,
    output logic         valid_W,
    output logic         regWrite_W,
    output logic         memtoReg_W,
    output logic [4:0]   rd_W,
    output logic [N-1:0] aluResult_W,
    output logic [N-1:0] readData_W
`ifdef MEM_MISALIGN_CHECK_EN
    ,
    output logic         misalign_W
`endif
);

    typedef struct packed {
        logic         valid;
        ctrl_t        ctrl;
        logic         zero;
        logic [N-1:0] alu;
        logic [N-1:0] wdata;
        logic [N-1:0] pcb;
    } m_t;

    typedef struct packed {
        logic         reg_write;
        logic         mem_to_reg;
        logic [4:0]   rd;
        logic [N-1:0] alu;
        logic [N-1:0] rdata;
    } w_t;

    state_t state;
    m_t     m_d, m_q;
    w_t     w_d, w_q;
    logic   access;
    logic   go_access;
    logic   retire;
    logic   misalign_E;
    logic   misalign_M;

    assign access  = (state == ACCESS);
    assign ready_E = !(access && !dm_ack);
    // An instruction leaves M on any edge where the stage is not stalled.
    assign retire  = m_q.valid && ready_E;

`ifdef MEM_MISALIGN_CHECK_EN
    assign misalign_E = (aluResult_E[2:0] != 3'b000);
    assign misalign_M = is_mem(m_q.ctrl) && (m_q.alu[2:0] != 3'b000);
`else
    assign misalign_E = 1'b0;
    assign misalign_M = 1'b0;
`endif

    assign go_access = valid_E && (MemRead_E || MemWrite_E) && !misalign_E;

    always_ff @(posedge clk) begin
        if (!reset)       state <= IDLE;
        else if (ready_E) state <= go_access ? ACCESS : IDLE;
    end

    always_comb begin
        m_d                 = '0;
        m_d.valid           = valid_E;
        m_d.ctrl.branch     = Branch_E;
        m_d.ctrl.mem_read   = MemRead_E;
        m_d.ctrl.mem_write  = MemWrite_E;
        m_d.ctrl.reg_write  = regWrite_E;
        m_d.ctrl.mem_to_reg = memtoReg_E;
        m_d.ctrl.rd         = rd_E;
        m_d.zero            = zero_E;
        m_d.alu             = aluResult_E;
        m_d.wdata           = writeData_E;
        m_d.pcb             = PCBranch_E;
    end

    exmem_reg #(.W($bits(m_t))) u_m_reg (
        .clk   (clk),
        .reset (reset),
        .en    (ready_E),
        .d     (m_d),
        .q     (m_q)
    );

    // Write wins when both read and write are set, so read data is zeroed.
    always_comb begin
        w_d            = '0;
        w_d.reg_write  = m_q.ctrl.reg_write && !misalign_M;
        w_d.mem_to_reg = m_q.ctrl.mem_to_reg;
        w_d.rd         = m_q.ctrl.rd;
        w_d.alu        = m_q.alu;
        if (access && m_q.ctrl.mem_read && !m_q.ctrl.mem_write)
            w_d.rdata = dm_rdata;
    end

    exmem_reg #(.W($bits(w_t))) u_w_reg (
        .clk   (clk),
        .reset (reset),
        .en    (retire),
        .d     (w_d),
        .q     (w_q)
    );

    exmem_reg #(.W(1)) u_w_valid (
        .clk   (clk),
        .reset (reset),
        .en    (1'b1),
        .d     (retire),
        .q     (valid_W)
    );

`ifdef MEM_MISALIGN_CHECK_EN
    exmem_reg #(.W(1)) u_w_misalign (
        .clk   (clk),
        .reset (reset),
        .en    (1'b1),
        .d     (retire && misalign_M),
        .q     (misalign_W)
    );
`endif

    assign PCSrc_M     = m_q.valid && m_q.ctrl.branch && m_q.zero;
    assign PCBranch_M  = m_q.pcb;
    assign dm_req      = access;
    assign dm_we       = access && m_q.ctrl.mem_write;
    assign dm_addr     = m_q.alu;
    assign dm_wdata    = m_q.wdata;

    assign regWrite_W  = w_q.reg_write;
    assign memtoReg_W  = w_q.mem_to_reg;
    assign rd_W        = w_q.rd;
    assign aluResult_W = w_q.alu;
    assign readData_W  = w_q.rdata;

endmodule

// File: tb/tb_memory_access.sv
// Bench for memory_access: vector table, handshake corner sequences and a
// randomized run against a transaction-level model of the stage.
module tb_memory_access;

    localparam int N = 64;

    logic         clk = 1'b0;
    logic         reset;
    logic         valid_E;
    logic [N-1:0] aluResult_E, writeData_E, PCBranch_E;
    logic         zero_E, Branch_E, MemRead_E, MemWrite_E, regWrite_E, memtoReg_E;
    logic [4:0]   rd_E;
    logic         ready_E, PCSrc_M;
    logic [N-1:0] PCBranch_M;
    logic         dm_req, dm_we;
    logic [N-1:0] dm_addr, dm_wdata;
    logic         dm_ack;
    logic [N-1:0] dm_rdata;
    logic         valid_W, regWrite_W, memtoReg_W;
    logic [4:0]   rd_W;
    logic [N-1:0] aluResult_W, readData_W;
`ifdef MEM_MISALIGN_CHECK_EN
    logic         misalign_W;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    memory_access #(.N(N)) dut (
        .clk         (clk),
        .reset       (reset),
        .valid_E     (valid_E),
        .aluResult_E (aluResult_E),
        .writeData_E (writeData_E),
        .PCBranch_E  (PCBranch_E),
        .zero_E      (zero_E),
        .Branch_E    (Branch_E),
        .MemRead_E   (MemRead_E),
        .MemWrite_E  (MemWrite_E),
        .regWrite_E  (regWrite_E),
        .memtoReg_E  (memtoReg_E),
        .rd_E        (rd_E),
        .ready_E     (ready_E),
        .PCSrc_M     (PCSrc_M),
        .PCBranch_M  (PCBranch_M),
        .dm_req      (dm_req),
        .dm_we       (dm_we),
        .dm_addr     (dm_addr),
        .dm_wdata    (dm_wdata),
        .dm_ack      (dm_ack),
        .dm_rdata    (dm_rdata),
        .valid_W     (valid_W),
        .regWrite_W  (regWrite_W),
        .memtoReg_W  (memtoReg_W),
        .rd_W        (rd_W),
        .aluResult_W (aluResult_W),
        .readData_W  (readData_W)
`ifdef MEM_MISALIGN_CHECK_EN
        ,
        .misalign_W  (misalign_W)
`endif
    );

    typedef struct {
        logic         valid;
        logic [N-1:0] alu;
        logic [N-1:0] pcb;
        logic         zero;
        logic         branch;
        logic         regw;
        logic [4:0]   rd;
        logic         exp_pcsrc;
        logic         exp_vw;
    } vec_t;

    typedef struct {
        logic [N-1:0] alu, wdata, pcb;
        logic         zero, branch, mr, mw, regw, m2r;
        logic [4:0]   rd;
    } ins_t;

    typedef struct {
        logic         regw, m2r, is_read;
        logic [4:0]   rd;
        logic [N-1:0] alu;
    } exp_t;

    task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic ins_t mk(input logic [N-1:0] alu, input logic [N-1:0] wdata,
                                input logic [N-1:0] pcb, input logic zero, input logic branch,
                                input logic mr, input logic mw, input logic regw,
                                input logic m2r, input logic [4:0] rd);
        ins_t i;
        i.alu = alu; i.wdata = wdata; i.pcb = pcb; i.zero = zero; i.branch = branch;
        i.mr = mr; i.mw = mw; i.regw = regw; i.m2r = m2r; i.rd = rd;
        return i;
    endfunction

    function automatic ins_t rnd_ins();
        ins_t i;
        int unsigned kind;
        kind     = $urandom_range(0, 4);
        i.alu    = {$urandom, $urandom};
        i.wdata  = {$urandom, $urandom};
        i.pcb    = {$urandom, $urandom};
        i.zero   = 1'($urandom_range(0, 1));
        i.rd     = 5'($urandom_range(0, 31));
        i.branch = (kind == 1);
        i.mr     = (kind == 2) || (kind == 4);
        i.mw     = (kind == 3) || (kind == 4);
        i.regw   = (kind == 0) || (kind == 2);
        i.m2r    = (kind == 2);
        if (i.mr || i.mw) i.alu[2:0] = 3'b000;
        return i;
    endfunction

    task automatic drive(input logic v, input ins_t i);
        valid_E     = v;
        aluResult_E = i.alu;
        writeData_E = i.wdata;
        PCBranch_E  = i.pcb;
        zero_E      = i.zero;
        Branch_E    = i.branch;
        MemRead_E   = i.mr;
        MemWrite_E  = i.mw;
        regWrite_E  = i.regw;
        memtoReg_E  = i.m2r;
        rd_E        = i.rd;
    endtask

    initial begin
        vec_t         vecs[6];
        ins_t         nop, cur;
        exp_t         exp_q[$];
        exp_t         e;
        int           req_cycles, stall, vw_seen;
        logic         busy, m_valid, m_taken, retire_due, have;
        int unsigned  req_wait, req_delay;
        logic [N-1:0] if_addr, if_wdata, ack_rdata;
        logic         if_we;

        nop = mk('0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);

        // reset state
        reset = 1'b0; dm_ack = 1'b0; dm_rdata = '0; drive(1'b0, nop);
        tick(); tick();
        check("rst_valid_W", valid_W, 0);
        check("rst_dm_req", dm_req, 0);
        check("rst_PCSrc_M", PCSrc_M, 0);
        check("rst_aluResult_W", aluResult_W, 0);
        check("rst_readData_W", readData_W, 0);
        check("rst_rd_W", rd_W, 0);
        check("rst_PCBranch_M", PCBranch_M, 0);
        reset = 1'b1;
        #1;
        check("rst_ready_E", ready_E, 1);

        // single-cycle ALU / branch vectors
        vecs[0] = '{1'b1, 64'h10,             64'h0,   1'b0, 1'b0, 1'b1, 5'd3,  1'b0, 1'b1};
        vecs[1] = '{1'b1, 64'h0,              64'h100, 1'b1, 1'b1, 1'b0, 5'd0,  1'b1, 1'b1};
        vecs[2] = '{1'b1, 64'h0,              64'h100, 1'b0, 1'b1, 1'b0, 5'd0,  1'b0, 1'b1};
        vecs[3] = '{1'b0, 64'h5,              64'h200, 1'b1, 1'b1, 1'b1, 5'd6,  1'b0, 1'b0};
        vecs[4] = '{1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8, 1'b0, 1'b0, 1'b1, 5'd31, 1'b0, 1'b1};
        vecs[5] = '{1'b1, 64'h1234,           64'h40,  1'b1, 1'b0, 1'b1, 5'd12, 1'b0, 1'b1};
        for (int k = 0; k < 6; k++) begin
            drive(vecs[k].valid, mk(vecs[k].alu, '0, vecs[k].pcb, vecs[k].zero, vecs[k].branch,
                                    1'b0, 1'b0, vecs[k].regw, 1'b0, vecs[k].rd));
            #1;
            check($sformatf("vec%0d_ready_E", k), ready_E, 1);
            tick();
            check($sformatf("vec%0d_PCSrc_M", k), PCSrc_M, vecs[k].exp_pcsrc);
            check($sformatf("vec%0d_PCBranch_M", k), PCBranch_M, vecs[k].pcb);
            drive(1'b0, nop);
            tick();
            check($sformatf("vec%0d_valid_W", k), valid_W, vecs[k].exp_vw);
            check($sformatf("vec%0d_PCSrc_off", k), PCSrc_M, 0);
            if (vecs[k].exp_vw) begin
                check($sformatf("vec%0d_aluResult_W", k), aluResult_W, vecs[k].alu);
                check($sformatf("vec%0d_rd_W", k), rd_W, vecs[k].rd);
                check($sformatf("vec%0d_regWrite_W", k), regWrite_W, vecs[k].regw);
                check($sformatf("vec%0d_readData_W", k), readData_W, 0);
            end
        end

        // load with ack on the third access cycle
        drive(1'b1, mk(64'h40, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd5));
        #1;
        tick();
        drive(1'b0, nop);
        req_cycles = 0; stall = 0;
        for (int c = 0; c < 3; c++) begin
            dm_ack   = (c == 2);
            dm_rdata = (c == 2) ? 64'hDEAD : 64'hBAD0;
            #1;
            if (dm_req)   req_cycles++;
            if (!ready_E) stall++;
            check("ld_dm_addr", dm_addr, 64'h40);
            check("ld_dm_we", dm_we, 0);
            check("ld_valid_W_wait", valid_W, 0);
            tick();
        end
        dm_ack = 1'b0;
        check("ld_req_cycles", req_cycles, 3);
        check("ld_stall_cycles", stall, 2);
        check("ld_valid_W", valid_W, 1);
        check("ld_readData_W", readData_W, 64'hDEAD);
        check("ld_aluResult_W", aluResult_W, 64'h40);
        check("ld_rd_W", rd_W, 5);
        check("ld_memtoReg_W", memtoReg_W, 1);
        check("ld_dm_req_off", dm_req, 0);
        tick();
        check("ld_valid_W_once", valid_W, 0);

        // store (and store+load), immediate ack, next instruction captured on ack edge
        for (int v = 0; v < 2; v++) begin
            drive(1'b1, mk(64'h8, 64'h55, '0, 1'b0, 1'b0, v[0], 1'b1, 1'b0, 1'b0, 5'd2));
            #1;
            tick();
            drive(1'b1, mk(64'h77, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd7));
            dm_ack = 1'b1; dm_rdata = 64'hBEEF;
            #1;
            check($sformatf("st%0d_dm_req", v), dm_req, 1);
            check($sformatf("st%0d_dm_we", v), dm_we, 1);
            check($sformatf("st%0d_dm_addr", v), dm_addr, 64'h8);
            check($sformatf("st%0d_dm_wdata", v), dm_wdata, 64'h55);
            check($sformatf("st%0d_ready_E", v), ready_E, 1);
            tick();
            dm_ack = 1'b0; drive(1'b0, nop);
            check($sformatf("st%0d_valid_W", v), valid_W, 1);
            check($sformatf("st%0d_regWrite_W", v), regWrite_W, 0);
            check($sformatf("st%0d_readData_W", v), readData_W, 0);
            check($sformatf("st%0d_rd_W", v), rd_W, 2);
            tick();
            check($sformatf("st%0d_next_valid_W", v), valid_W, 1);
            check($sformatf("st%0d_next_alu_W", v), aluResult_W, 64'h77);
            check($sformatf("st%0d_next_rd_W", v), rd_W, 7);
            tick();
            check($sformatf("st%0d_idle_valid_W", v), valid_W, 0);
        end

        // reset in the middle of an access, ack arriving afterwards
        drive(1'b1, mk(64'h40, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd9));
        #1;
        tick();
        drive(1'b0, nop);
        #1;
        check("rsta_dm_req_on", dm_req, 1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        #1;
        check("rsta_dm_req_off", dm_req, 0);
        dm_ack = 1'b1; dm_rdata = 64'h1111;
        vw_seen = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            dm_ack = 1'b0;
            if (valid_W) vw_seen++;
        end
        check("rsta_valid_W_never", vw_seen, 0);
        check("rsta_dm_req_idle", dm_req, 0);
        check("rsta_ready_E", ready_E, 1);

`ifdef MEM_MISALIGN_CHECK_EN
        drive(1'b1, mk(64'h13, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd4));
        #1;
        tick();
        drive(1'b0, nop);
        #1;
        check("mis_dm_req", dm_req, 0);
        check("mis_ready_E", ready_E, 1);
        tick();
        check("mis_valid_W", valid_W, 1);
        check("mis_misalign_W", misalign_W, 1);
        check("mis_regWrite_W", regWrite_W, 0);
        tick();
        check("mis_misalign_off", misalign_W, 0);
        check("mis_valid_W_off", valid_W, 0);
`else
        drive(1'b1, mk(64'h13, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd4));
        #1;
        tick();
        drive(1'b0, nop);
        dm_ack = 1'b1; dm_rdata = 64'h2222;
        #1;
        check("mis_dm_req", dm_req, 1);
        check("mis_dm_addr", dm_addr, 64'h13);
        tick();
        dm_ack = 1'b0;
        check("mis_valid_W", valid_W, 1);
        check("mis_readData_W", readData_W, 64'h2222);
`endif

        // randomized run against a transaction-level model
        reset = 1'b0; dm_ack = 1'b0; drive(1'b0, nop);
        tick(); tick();
        reset = 1'b1;
        busy = 1'b0; m_valid = 1'b0; m_taken = 1'b0; retire_due = 1'b0; have = 1'b0;
        req_wait = 0; req_delay = 0; if_addr = '0; if_wdata = '0; if_we = 1'b0; ack_rdata = '0;
        cur = nop;
        for (int cyc = 0; cyc < 600; cyc++) begin
            logic ack, ready_m;
            check("rnd_valid_W", valid_W, retire_due);
            if (valid_W && retire_due && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("rnd_regWrite_W", regWrite_W, e.regw);
                check("rnd_memtoReg_W", memtoReg_W, e.m2r);
                check("rnd_rd_W", rd_W, e.rd);
                check("rnd_aluResult_W", aluResult_W, e.alu);
                check("rnd_readData_W", readData_W, e.is_read ? ack_rdata : '0);
            end
            check("rnd_dm_req", dm_req, busy);
            if (busy) begin
                check("rnd_dm_addr", dm_addr, if_addr);
                check("rnd_dm_we", dm_we, if_we);
                check("rnd_dm_wdata", dm_wdata, if_wdata);
            end
            check("rnd_PCSrc_M", PCSrc_M, m_taken);

            if (busy) ack = (req_wait == req_delay);
            else      ack = ($urandom_range(0, 4) == 0);
            dm_ack   = ack;
            dm_rdata = {$urandom, $urandom};
            if (busy && ack) ack_rdata = dm_rdata;
            if (!have && cyc < 560 && $urandom_range(0, 2) != 0) begin
                cur  = rnd_ins();
                have = 1'b1;
            end
            drive(have, have ? cur : rnd_ins());
            #1;
            ready_m = !busy || ack;
            check("rnd_ready_E", ready_E, ready_m);
            retire_due = m_valid && ready_m;
            if (busy && !ack) req_wait++;
            if (ready_m) begin
                m_valid = have;
                m_taken = have && cur.branch && cur.zero;
                busy    = have && (cur.mr || cur.mw);
                if (have) begin
                    exp_q.push_back('{cur.regw, cur.m2r, cur.mr && !cur.mw, cur.rd, cur.alu});
                    if (busy) begin
                        req_wait  = 0;
                        req_delay = $urandom_range(0, 3);
                        if_addr   = cur.alu;
                        if_wdata  = cur.wdata;
                        if_we     = cur.mw;
                    end
                end
                have = 1'b0;
            end
            tick();
        end
        dm_ack = 1'b0;
        drive(1'b0, nop);
        check("rnd_drain", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/memory_access.md
MEMORY_ACCESS -- requirements
Module: memory_access

Interface
REQ-001 Parameter: N, default 64, datapath width in bits.
REQ-002 The block SHALL use one clock; reset is synchronous and active-low; ports clk and reset.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 reset  in  1  synchronous, active-low reset, sampled on rising clk.
REQ-005 valid_E  in  1  execute stage presents an instruction this cycle.
REQ-006 aluResult_E, writeData_E, PCBranch_E  in  N each  execute stage results.
REQ-007 zero_E  in  1  ALU zero flag.
REQ-008 Branch_E, MemRead_E, MemWrite_E, regWrite_E, memtoReg_E  in  1 each  control bits.
REQ-009 rd_E  in  5  destination register.
REQ-010 ready_E  out  1  stage can accept a new instruction (not stalled).
REQ-011 PCSrc_M  out  1  taken-branch select to fetch; PCBranch_M  out  N  branch target.
REQ-012 dm_req, dm_we  out  1 each; dm_addr, dm_wdata  out  N each  data-memory request.
REQ-013 dm_ack  in  1; dm_rdata  in  N  data-memory completion and read data.
REQ-014 valid_W, regWrite_W, memtoReg_W  out  1 each; rd_W  out  5; aluResult_W, readData_W  out  N each  writeback-register outputs.

Function
REQ-015 The M register SHALL capture all *_E inputs on a rising edge when ready_E=1; valid_M takes valid_E.
REQ-016 FSM states IDLE and ACCESS; IDLE->ACCESS when captured valid_E & (MemRead_E|MemWrite_E); ACCESS->IDLE on the edge where dm_ack=1.
REQ-017 In ACCESS: dm_req=1; dm_we=MemWrite_M; dm_addr=aluResult_M; dm_wdata=writeData_M; all are held stable until dm_ack.
REQ-018 ready_E = !(state==ACCESS & !dm_ack); an instruction presented with dm_ack=1 SHALL be captured on that same edge.
REQ-019 Non-memory instruction: W register written on the edge after M capture (latency 1 edge M->W).
REQ-020 Memory instruction: W register written on the edge where dm_ack=1; readData_W=dm_rdata when MemRead_M, else 0.
REQ-021 valid_W SHALL be 1 for exactly one cycle per retired instruction; 0 while a stall holds the M register.
REQ-022 PCSrc_M = valid_M & Branch_M & zero_M, combinational from the M register; PCBranch_M = PCBranch_M register.
REQ-023 When both MemRead_E and MemWrite_E are set, the write SHALL take priority (dm_we=1, readData_W=0).
REQ-024 dm_ack received in IDLE SHALL be ignored.

Reset
REQ-025 When reset=0: state=IDLE; valid_M=0, valid_W=0; all M and W registers=0; dm_req=0; PCSrc_M=0; ready_E=1 from the next cycle.
REQ-026 Reset during ACCESS SHALL abort the access, with dm_req=0 on the following cycle; a late dm_ack is discarded per REQ-024.

Configuration
REQ-027 Macro MEM_MISALIGN_CHECK_EN: when defined, a memory instruction with dm_addr[2:0]!=0 SHALL skip ACCESS, drive dm_req=0, and retire next edge with output misalign_W=1 and regWrite_W=0.
REQ-028 When MEM_MISALIGN_CHECK_EN is not defined, misalign_W SHALL not exist and misaligned addresses are issued unchanged.

Structure
REQ-029 Package memory_pkg SHALL hold the FSM state enum (IDLE, ACCESS) and a packed struct of the five control bits plus rd.
REQ-030 Sub-module exmem_reg (enable-qualified, synchronous active-low reset pipeline register, width parameter) SHALL implement both the M and W registers.

Verification
REQ-031 ADD: aluResult_E=0x10, regWrite_E=1, rd_E=3 -> next edge valid_W=1, aluResult_W=0x10, rd_W=3, ready_E stays 1.
REQ-032 LDUR: aluResult_E=0x40, MemRead_E=1, dm_ack after 3 cycles with dm_rdata=0xDEAD -> dm_req=1 for 3 cycles, ready_E=0 for 2 cycles, readData_W=0xDEAD, valid_W=1 for one cycle.
REQ-033 STUR: aluResult_E=0x8, writeData_E=0x55, dm_ack the first cycle -> dm_we=1, dm_addr=0x8, dm_wdata=0x55, zero stall cycles, regWrite_W=0.
REQ-034 CBZ: Branch_E=1, zero_E=1, PCBranch_E=0x100 -> PCSrc_M=1 and PCBranch_M=0x100 for one cycle; repeat with zero_E=0 -> PCSrc_M=0.
REQ-035 reset=0 asserted during ACCESS, then dm_ack=1 after release -> dm_req=0, valid_W never 1, state IDLE.
REQ-036 With MEM_MISALIGN_CHECK_EN: MemRead_E=1, aluResult_E=0x13 -> dm_req=0, misalign_W=1, regWrite_W=0.
